// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter.
//   SIZE_*   : access-size codes seen on c_size/d_size/mem_size
//   port_id_e: identifies which requester owns an outstanding response
package dmem_arb_pkg;

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_id_e;

endpackage

// File: rtl/dmem_align_check.sv
// dmem_align_check
//   Combinational alignment check for one requester.
//   size       in  access size code (codes other than byte/half are word)
//   addr_lo    in  byte address bits [1:0]
//   misaligned out 1 when the access crosses its natural boundary
//   Only instantiated when DMEM_ARB_ALIGN_CHECK_EN is defined.
module dmem_align_check
    import dmem_arb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b0;
        if (size == SIZE_BYTE) begin
            misaligned = 1'b0;
        end else if (size == SIZE_HALF) begin
            misaligned = addr_lo[0];
        end else begin
            misaligned = (addr_lo != 2'b00);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Arbitrates the single-ported data memory between the CPU load/store
//   unit (port C) and the DMA/debug port (port D). C has fixed priority;
//   a starvation counter forces a D win after STARVE_MAX consecutive losses.
//
//   clk, rst_n                 clock, synchronous active-low reset
//   {c,d}_req/we/size/addr/wdata  requester access fields
//   {c,d}_gnt                  combinational grant (accepted when req && gnt)
//   {c,d}_rvalid/rdata         load response, one cycle after acceptance
//   mem_addr/wdata/wr/size     memory drive, combinational from the winner
//   mem_rdata                  memory read data (1-cycle registered latency)
//   {c,d}_err                  misalignment error pulse, only present when
//                              DMEM_ARB_ALIGN_CHECK_EN is defined
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 11,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          c_req,
    output logic          c_gnt,
    input  logic          c_we,
    input  logic [2:0]    c_size,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,

    input  logic          d_req,
    output logic          d_gnt,
    input  logic          d_we,
    input  logic [2:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wr,
    output logic [2:0]    mem_size,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    ,
    output logic          c_err,
    output logic          d_err
`endif
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          resp_pending_q, resp_pending_d;
    port_id_e      resp_owner_q, resp_owner_d;
    logic          err_pending_q, err_pending_d;

    logic starve_hit;
    logic any_gnt;
    logic acc_we;
    logic mis;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic c_mis, d_mis;

    dmem_align_check u_align_c (
        .size       (c_size),
        .addr_lo    (c_addr[1:0]),
        .misaligned (c_mis)
    );

    dmem_align_check u_align_d (
        .size       (d_size),
        .addr_lo    (d_addr[1:0]),
        .misaligned (d_mis)
    );
`endif

    always_comb begin
        starve_hit = d_req && (starve_cnt_q == STARVE_LIM);

        // Grants are held low during reset so nothing reaches memory.
        c_gnt = rst_n && c_req && !starve_hit;
        d_gnt = rst_n && d_req && (!c_req || starve_hit);
        any_gnt = c_gnt || d_gnt;

        // Port C drives the memory bus whenever D is not the winner,
        // including idle cycles.
        mem_addr  = d_gnt ? d_addr  : c_addr;
        mem_wdata = d_gnt ? d_wdata : c_wdata;
        mem_size  = d_gnt ? d_size  : c_size;
        acc_we    = d_gnt ? d_we    : c_we;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
        mis = any_gnt && (d_gnt ? d_mis : c_mis);
`else
        mis = 1'b0;
`endif

        // A misaligned access is still granted (so the requester moves on)
        // but never touches memory; it reports through err instead.
        mem_wr         = any_gnt && acc_we && !mis;
        resp_pending_d = any_gnt && !acc_we && !mis;
        err_pending_d  = mis;
        resp_owner_d   = any_gnt ? (d_gnt ? PORT_D : PORT_C) : resp_owner_q;

        starve_cnt_d = starve_cnt_q;
        if (!d_req || d_gnt) begin
            starve_cnt_d = '0;
        end else if (c_gnt && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q   <= '0;
            resp_pending_q <= 1'b0;
            resp_owner_q   <= PORT_C;
            err_pending_q  <= 1'b0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            resp_pending_q <= resp_pending_d;
            resp_owner_q   <= resp_owner_d;
            err_pending_q  <= err_pending_d;
        end
    end

    // Gating with rst_n drops a response whose cycle coincides with reset.
    always_comb begin
        c_rvalid = rst_n && resp_pending_q && (resp_owner_q == PORT_C);
        d_rvalid = rst_n && resp_pending_q && (resp_owner_q == PORT_D);
        c_rdata  = mem_rdata;
        d_rdata  = mem_rdata;
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    always_comb begin
        c_err = rst_n && err_pending_q && (resp_owner_q == PORT_C);
        d_err = rst_n && err_pending_q && (resp_owner_q == PORT_D);
    end
`else
    logic unused_err;
    assign unused_err = err_pending_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter with a byte-lane memory model.
//   Expected load data comes from a shadow image updated when the bench
//   issues stores; expected responses are queued on acceptance and
//   compared one cycle later by a monitor.
module tb_dmem_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          c_req, c_we, d_req, d_we;
    logic [2:0]    c_size, d_size;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_gnt, d_gnt, c_rvalid, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_wr;
    logic [2:0]    mem_size;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic          c_err, d_err;
`endif

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_gnt(c_gnt), .c_we(c_we), .c_size(c_size),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_gnt(d_gnt), .d_we(d_we), .d_size(d_size),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_size(mem_size), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        , .c_err(c_err), .d_err(d_err)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [7:0]    mem    [0:2047];
    logic [7:0]    shadow [0:2047];
    logic [AW-1:0] wa;

    always @(posedge clk) begin
        mem_rdata <= {mem[{mem_addr[10:2], 2'b11}], mem[{mem_addr[10:2], 2'b10}],
                      mem[{mem_addr[10:2], 2'b01}], mem[{mem_addr[10:2], 2'b00}]};
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (i == 0 || (i == 1 && mem_size != 3'b000) ||
                    (mem_size != 3'b000 && mem_size != 3'b001)) begin
                    wa = mem_addr + AW'(i);
                    mem[wa] = mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // ---------------- checking ----------------
    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] data;
        int          stamp;
    } exp_t;

    exp_t q[$];

    function automatic bit misaligned(input logic [2:0] sz, input logic [AW-1:0] a);
        if (sz == 3'b000) return 1'b0;
        if (sz == 3'b001) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    // Record the effect of an access the bench expects to be accepted now.
    task automatic accept(input bit port);
        logic          we;
        logic [2:0]    sz;
        logic [AW-1:0] a, b;
        logic [31:0]   wd;
        exp_t          e;
        we = port ? d_we    : c_we;
        sz = port ? d_size  : c_size;
        a  = port ? d_addr  : c_addr;
        wd = port ? d_wdata : c_wdata;
        e.port  = port;
        e.err   = 1'b0;
        e.data  = '0;
        e.stamp = cyc;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        if (misaligned(sz, a)) begin
            e.err = 1'b1;
            q.push_back(e);
            return;
        end
`endif
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (i == 0 || (i == 1 && sz != 3'b000) || (sz != 3'b000 && sz != 3'b001)) begin
                    b = a + AW'(i);
                    shadow[b] = wd[8*i +: 8];
                end
            end
        end else begin
            e.data = {shadow[{a[10:2], 2'b11}], shadow[{a[10:2], 2'b10}],
                      shadow[{a[10:2], 2'b01}], shadow[{a[10:2], 2'b00}]};
            q.push_back(e);
        end
    endtask

    // Response monitor: an entry queued in cycle N must appear in cycle N+1.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("one_gnt", 32'(c_gnt & d_gnt), 32'd0);
            chk("wr_without_gnt", 32'(mem_wr & ~(c_gnt | d_gnt)), 32'd0);
            if (q.size() > 0 && q[0].stamp == cyc - 1) begin
                e = q.pop_front();
                chk("c_rvalid", 32'(c_rvalid), 32'(!e.err && e.port == 1'b0));
                chk("d_rvalid", 32'(d_rvalid), 32'(!e.err && e.port == 1'b1));
                if (!e.err) chk("rdata", e.port ? d_rdata : c_rdata, e.data);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                chk("c_err", 32'(c_err), 32'(e.err && e.port == 1'b0));
                chk("d_err", 32'(d_err), 32'(e.err && e.port == 1'b1));
`endif
            end else begin
                chk("c_rvalid_idle", 32'(c_rvalid), 32'd0);
                chk("d_rvalid_idle", 32'(d_rvalid), 32'd0);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                chk("c_err_idle", 32'(c_err), 32'd0);
                chk("d_err_idle", 32'(d_err), 32'd0);
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_c(input logic req, input logic we, input logic [2:0] sz,
                         input logic [AW-1:0] a, input logic [31:0] wd);
        c_req = req; c_we = we; c_size = sz; c_addr = a; c_wdata = wd;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [2:0] sz,
                         input logic [AW-1:0] a, input logic [31:0] wd);
        d_req = req; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    endtask

    task automatic idle();
        set_c(1'b0, 1'b0, 3'b010, '0, '0);
        set_d(1'b0, 1'b0, 3'b010, '0, '0);
    endtask

    // Wait for the sampling point, check grants, record accepted accesses.
    task automatic sample(input logic ec, input logic ed, input string tag);
        @(negedge clk);
        chk({tag, "_c_gnt"}, 32'(c_gnt), 32'(ec));
        chk({tag, "_d_gnt"}, 32'(d_gnt), 32'(ed));
        if (ec) accept(1'b0);
        if (ed) accept(1'b1);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i]    = 8'h00;
            shadow[i] = 8'h00;
        end
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Requests during reset must not be granted or reach memory.
        set_c(1'b1, 1'b1, 3'b010, 11'h010, 32'h0BAD_0BAD);
        @(negedge clk);
        chk("rst_c_gnt", 32'(c_gnt), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        adv();
        rst_n = 1'b1;
        idle();
        adv();

        // Word store then load at 0x010.
        set_c(1'b1, 1'b1, 3'b010, 11'h010, 32'hDEAD_BEEF);
        sample(1'b1, 1'b0, "t1_st");
        chk("t1_mem_wr", 32'(mem_wr), 32'd1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h010);
        adv();
        set_c(1'b1, 1'b0, 3'b010, 11'h010, 32'h0);
        sample(1'b1, 1'b0, "t1_ld");
        chk("t1_ld_wr", 32'(mem_wr), 32'd0);
        adv();
        idle();
        sample(1'b0, 1'b0, "t1_resp");
        chk("t1_rvalid", 32'(c_rvalid), 32'd1);
        chk("t1_rdata", c_rdata, 32'hDEAD_BEEF);
        adv();

        // Continuous contention: C,C,C,C,D repeating.
        set_c(1'b1, 1'b0, 3'b010, 11'h010, 32'h0);
        set_d(1'b1, 1'b0, 3'b010, 11'h004, 32'h0);
        for (int i = 0; i < 10; i++) begin
            sample((i % 5) != 4, (i % 5) == 4, "t2");
            adv();
        end
        idle();
        sample(1'b0, 1'b0, "t2_drain");
        adv();

        // D byte store 0xA5 to 0x003 with C idle.
        set_d(1'b1, 1'b1, 3'b000, 11'h003, 32'h0000_00A5);
        sample(1'b0, 1'b1, "t3");
        chk("t3_mem_size", 32'(mem_size), 32'd0);
        chk("t3_mem_wr", 32'(mem_wr), 32'd1);
        chk("t3_mem_addr", 32'(mem_addr), 32'h003);
        chk("t3_mem_wdata", mem_wdata[7:0], 32'hA5);
        adv();
        idle();
        sample(1'b0, 1'b0, "t3_after");
        chk("t3_wr_pulse", 32'(mem_wr), 32'd0);
        adv();

        // Back-to-back C loads at 0x000 and 0x004.
        set_c(1'b1, 1'b1, 3'b010, 11'h004, 32'h1234_5678);
        sample(1'b1, 1'b0, "t4_st");
        adv();
        set_c(1'b1, 1'b0, 3'b010, 11'h000, 32'h0);
        sample(1'b1, 1'b0, "t4_ld0");
        adv();
        set_c(1'b1, 1'b0, 3'b010, 11'h004, 32'h0);
        sample(1'b1, 1'b0, "t4_ld1");
        chk("t4_rdata0", c_rdata, 32'hA500_0000);
        adv();
        idle();
        sample(1'b0, 1'b0, "t4_drain");
        chk("t4_rdata1", c_rdata, 32'h1234_5678);
        adv();

        // Reset in the cycle after an accepted D load.
        set_c(1'b1, 1'b0, 3'b010, 11'h010, 32'h0);
        set_d(1'b1, 1'b0, 3'b010, 11'h004, 32'h0);
        for (int i = 0; i < 5; i++) begin
            sample(i != 4, i == 4, "t5_pre");
            adv();
        end
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("t5_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("t5_gnt", 32'({c_gnt, d_gnt}), 32'd0);
        adv();
        rst_n = 1'b1;
        // Counter must restart from zero: four C wins before D.
        for (int i = 0; i < 5; i++) begin
            sample(i != 4, i == 4, "t5_post");
            adv();
        end
        idle();
        sample(1'b0, 1'b0, "t5_drain");
        adv();

`ifdef DMEM_ARB_ALIGN_CHECK_EN
        // Misaligned word store to 0x002 is granted but not issued.
        set_c(1'b1, 1'b1, 3'b010, 11'h002, 32'hFFFF_FFFF);
        sample(1'b1, 1'b0, "t6_st");
        chk("t6_mem_wr", 32'(mem_wr), 32'd0);
        adv();
        idle();
        sample(1'b0, 1'b0, "t6_err");
        chk("t6_c_err", 32'(c_err), 32'd1);
        adv();
        set_c(1'b1, 1'b0, 3'b010, 11'h000, 32'h0);
        sample(1'b1, 1'b0, "t6_ld0");
        adv();
        set_c(1'b1, 1'b0, 3'b010, 11'h004, 32'h0);
        sample(1'b1, 1'b0, "t6_ld1");
        chk("t6_rdata0", c_rdata, 32'hA500_0000);
        adv();
        idle();
        sample(1'b0, 1'b0, "t6_drain");
        chk("t6_rdata1", c_rdata, 32'h1234_5678);
        adv();
`endif

        repeat (2) adv();
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
